ps2_keyboard_receiver: RTL and testbench

Receives the 11-bit PS/2 keyboard serial frame (start, 8 data LSB-first, odd parity, stop) and drives the processor's `ps2_key_pressed` / `ps2_out[7:0]` tty inputs. It decodes scan-code prefixes so that only make codes are presented: break sequences (`F0 xx`) are swallowed, and extended keys (`E0 xx`) are flagged. It sits between the keyboard pins and the processor top level, in the processor clock domain.

---
 rtl/ps2_keyboard_receiver.sv | 153 +++++++++++++++
 tb/tb_ps2_keyboard_receiver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_keyboard_receiver
// Brief    : PS/2 keyboard frame receiver with make/break/extended decoding
// Revision : 1.0 - initial release
// ============================================================================
module ps2_keyboard_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       ps2_key_pressed,
    output logic [7:0] ps2_out,
    output logic       ps2_extended,
    output logic       frame_error
);

    localparam int c_FW  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_FW-1:0] c_F_MAX  = c_FW'(FILTER_LEN - 1);
    localparam logic [c_TW-1:0] c_TO_MAX = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] c_BREAK = 8'hF0;
    localparam logic [7:0] c_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic [1:0]      r_clk_sync;
    logic [1:0]      r_data_sync;
    logic            r_filt_level;
    logic [c_FW-1:0] r_filt_cnt;
    logic            w_clk_s;
    logic            w_data_s;
    logic            w_fall;

    state_t          r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par_ok;
    logic [c_TW-1:0] r_to_cnt;
    logic            r_brk_pend;
    logic            r_ext_pend;

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];
    // Fall is flagged in the same cycle the filtered level would flip to 0.
    assign w_fall   = r_filt_level & ~w_clk_s & (r_filt_cnt == c_F_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_clk_sync   <= 2'b11;
            r_data_sync  <= 2'b11;
            r_filt_level <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clock};
            r_data_sync <= {r_data_sync[0], ps2_data};
            if (w_clk_s == r_filt_level) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_F_MAX) begin
                r_filt_level <= w_clk_s;
                r_filt_cnt   <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_par_ok        <= 1'b0;
            r_to_cnt        <= '0;
            r_brk_pend      <= 1'b0;
            r_ext_pend      <= 1'b0;
            ps2_key_pressed <= 1'b0;
            ps2_out         <= 8'h00;
            ps2_extended    <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            ps2_key_pressed <= 1'b0;
            frame_error     <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!w_data_s) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift <= {w_data_s, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        r_par_ok <= ^{r_shift, w_data_s};
                        r_state  <= S_STOP;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        if (r_par_ok && w_data_s) begin
                            if (r_shift == c_BREAK) begin
                                r_brk_pend <= 1'b1;
                            end else if (r_shift == c_EXT) begin
                                r_ext_pend <= 1'b1;
                            end else if (r_brk_pend) begin
                                r_brk_pend <= 1'b0;
                                r_ext_pend <= 1'b0;
                            end else begin
                                ps2_out         <= r_shift;
                                ps2_extended    <= r_ext_pend;
                                ps2_key_pressed <= 1'b1;
                                r_ext_pend      <= 1'b0;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            r_brk_pend  <= 1'b0;
                            r_ext_pend  <= 1'b0;
                        end
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == c_TO_MAX) begin
                    r_state     <= S_IDLE;
                    r_to_cnt    <= '0;
                    frame_error <= 1'b1;
                    r_brk_pend  <= 1'b0;
                    r_ext_pend  <= 1'b0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_keyboard_receiver
// Brief    : Directed self-checking bench with an event-level scan-code model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_receiver;

    localparam int c_FILTER  = 4;
    localparam int c_TIMEOUT = 200;
    localparam int c_HALF    = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ps2_key_pressed;
    logic [7:0] ps2_out;
    logic       ps2_extended;
    logic       frame_error;

    ps2_keyboard_receiver #(
        .FILTER_LEN    (c_FILTER),
        .TIMEOUT_CYCLES(c_TIMEOUT)
    ) u_dut (
        .clock          (clk),
        .reset          (rst_n),
        .ps2_clock      (ps2_clock),
        .ps2_data       (ps2_data),
        .ps2_key_pressed(ps2_key_pressed),
        .ps2_out        (ps2_out),
        .ps2_extended   (ps2_extended),
        .frame_error    (frame_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         ext;
    } ev_t;

    ev_t        q[$];
    logic [7:0] m_out = 8'h00;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    bit         m_extp = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         n_key = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scan-code rules applied to one received frame outcome.
    task automatic model_byte(input logic [7:0] b, input bit good);
        ev_t e;
        if (!good) begin
            e = '{1'b1, 8'h00, 1'b0};
            q.push_back(e);
            m_brk  = 1'b0;
            m_extp = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_extp = 1'b1;
        end else if (m_brk) begin
            m_brk  = 1'b0;
            m_extp = 1'b0;
        end else begin
            e = '{1'b0, b, m_extp};
            q.push_back(e);
            m_extp = 1'b0;
        end
    endtask

    // Drives the first nbits of a frame; glitch_at selects a bit whose high
    // phase gets a short low pulse on ps2_clock.
    task automatic drive_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int glitch_at);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (i == glitch_at) begin
                tick(c_HALF / 2);
                ps2_clock = 1'b0;
                tick(c_FILTER - 1);
                ps2_clock = 1'b1;
                tick(c_HALF - c_HALF / 2 - (c_FILTER - 1));
            end else begin
                tick(c_HALF);
            end
            ps2_clock = 1'b0;
            tick(c_HALF);
            ps2_clock = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_at);
        model_byte(b, !(bad_par || bad_stop));
        drive_bits(b, bad_par, bad_stop, 11, glitch_at);
        tick(2 * c_HALF);
        chk("drained", q.size(), 0);
    endtask

    task automatic do_reset();
        q.delete();
        m_out  = 8'h00;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_extp = 1'b0;
        rst_n  = 1'b0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (ps2_key_pressed && frame_error) chk("pulse_overlap", 1, 0);
        if (ps2_key_pressed || frame_error) begin
            if (ps2_key_pressed) n_key++;
            if (frame_error) n_err++;
            if (q.size() == 0) begin
                chk("unexpected_pulse", {ps2_key_pressed, frame_error}, 0);
            end else begin
                e = q.pop_front();
                chk("pulse_kind_err", frame_error, e.is_err);
                if (!e.is_err) begin
                    m_out = e.code;
                    m_ext = e.ext;
                end
            end
        end
        chk("ps2_out", ps2_out, m_out);
        chk("ps2_extended", ps2_extended, m_ext);
    end

    initial begin
        int k0;
        int e0;
        do_reset();
        tick(3);
        chk("rst_out", ps2_out, 8'h00);
        chk("rst_ext", ps2_extended, 0);
        chk("rst_key", ps2_key_pressed, 0);
        chk("rst_err", frame_error, 0);
        rst_n = 1'b1;
        tick(20);

        k0 = n_key;
        send(8'h1C, 0, 0, -1);
        chk("lit_1c_out", ps2_out, 8'h1C);
        chk("lit_1c_ext", ps2_extended, 0);
        chk("lit_1c_pulses", n_key - k0, 1);

        k0 = n_key;
        send(8'hF0, 0, 0, -1);
        send(8'h1C, 0, 0, -1);
        chk("lit_break_nopulse", n_key - k0, 0);
        chk("lit_break_out", ps2_out, 8'h1C);

        send(8'hE0, 0, 0, -1);
        send(8'h75, 0, 0, -1);
        chk("lit_e075_out", ps2_out, 8'h75);
        chk("lit_e075_ext", ps2_extended, 1);
        send(8'h29, 0, 0, -1);
        chk("lit_29_out", ps2_out, 8'h29);
        chk("lit_29_ext", ps2_extended, 0);

        k0 = n_key;
        e0 = n_err;
        send(8'h1C, 1, 0, -1);
        chk("lit_par_err", n_err - e0, 1);
        chk("lit_par_nokey", n_key - k0, 0);
        send(8'hE0, 0, 0, -1);
        send(8'h75, 0, 1, -1);
        send(8'h6B, 0, 0, -1);
        chk("lit_6b_out", ps2_out, 8'h6B);
        chk("lit_6b_ext", ps2_extended, 0);

        // Extended break: E0 F0 75 swallows the key.
        send(8'hE0, 0, 0, -1);
        send(8'hF0, 0, 0, -1);
        send(8'h75, 0, 0, -1);
        chk("lit_e0f0_out", ps2_out, 8'h6B);
        send(8'h1C, 0, 0, -1);
        chk("lit_after_e0f0_ext", ps2_extended, 0);

        e0 = n_err;
        model_byte(8'h00, 0);
        drive_bits(8'h29, 0, 0, 5, -1);
        tick(c_TIMEOUT + 40);
        chk("timeout_drained", q.size(), 0);
        chk("lit_timeout_err", n_err - e0, 1);
        send(8'h29, 0, 0, -1);
        chk("lit_to_29_out", ps2_out, 8'h29);

        send(8'h75, 0, 0, 4);
        chk("lit_glitch_out", ps2_out, 8'h75);
        chk("lit_glitch_ext", ps2_extended, 0);

        e0 = n_err;
        drive_bits(8'h1C, 0, 0, 5, -1);
        do_reset();
        tick(3);
        chk("midrst_out", ps2_out, 8'h00);
        chk("midrst_ext", ps2_extended, 0);
        rst_n = 1'b1;
        tick(c_TIMEOUT + 20);
        chk("midrst_noerr", n_err - e0, 0);
        send(8'h1C, 0, 0, -1);
        chk("lit_final_out", ps2_out, 8'h1C);
        chk("lit_final_ext", ps2_extended, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
